// File: rtl/ascon_pkg.sv
// ASCON substitution-layer constants: default 5-bit S-box table and loader FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package ascon_pkg;

    localparam int SBOX_LUT_ENTRIES = 32;

    // Entry i is SBOX_LUT_DEFAULT[i]; the concatenation lists entry 31 first.
    localparam logic [31:0][4:0] SBOX_LUT_DEFAULT = {
        5'h17, 5'h0f, 5'h0a, 5'h16, 5'h19, 5'h01, 5'h0c, 5'h10,
        5'h18, 5'h11, 5'h0d, 5'h00, 5'h0e, 5'h07, 5'h13, 5'h1e,
        5'h1c, 5'h06, 5'h03, 5'h1d, 5'h12, 5'h08, 5'h05, 5'h1b,
        5'h02, 5'h09, 5'h15, 5'h1a, 5'h14, 5'h1f, 5'h0b, 5'h04
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } lut_state_t;

endpackage

// File: rtl/reg_if_pkg.sv
// Shared register-interface request/response typedefs.
// Latency: n/a (types only).
// Backpressure: a request completes on any cycle with valid && ready.
package reg_if_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/sbox_lut_loader.sv
// Programs the 32-entry S-box LUT over the register bus, optionally reading every entry back.
// Latency: first request one cycle after start; 32 (+32 with verify) transactions, done one cycle after the last.
// Backpressure: request held stable until valid && ready; each ready=0 cycle adds one cycle.
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   start_i                 begin a load (sampled in IDLE only)
//   use_custom_i, verify_i  source select / read-back enable, sampled with start_i
//   lut_i                   custom table, captured at start
//   reg_req_o, reg_rsp_i    register-bus initiator port
//   busy_o, done_o          load in progress / one-cycle completion pulse
//   err_o, err_idx_o        sticky failure flag and index of the failing entry
module sbox_lut_loader
    import reg_if_pkg::*;
    import ascon_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             use_custom_i,
    input  logic             verify_i,
    input  logic [31:0][4:0] lut_i,
    output reg_req_t         reg_req_o,
    input  reg_rsp_t         reg_rsp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic [4:0]       err_idx_o
);

    localparam logic [4:0] LAST_IDX = 5'(SBOX_LUT_ENTRIES - 1);

    lut_state_t       state_q, state_d;
    logic [4:0]       idx_q, idx_d;
    logic [4:0]       next_idx;
    logic [31:0][4:0] tbl_q;
    logic [31:0][4:0] tbl_src;
    logic             tbl_load;
    logic             verify_q, verify_d;
    reg_req_t         req_q, req_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [4:0]       err_idx_q, err_idx_d;
    logic             xfer;
    logic             rd_bad;
    logic             unused_rdata_hi;

    // Upper read-data bits carry nothing for a 5-bit entry.
    assign unused_rdata_hi = ^reg_rsp_i.rdata[31:5];

    assign tbl_src  = use_custom_i ? lut_i : SBOX_LUT_DEFAULT;
    assign xfer     = req_q.valid && reg_rsp_i.ready;
    assign next_idx = idx_q + 5'd1;
    assign rd_bad   = (reg_rsp_i.rdata[4:0] != tbl_q[idx_q]);

    // The address adder wraps modulo 2^32 by construction.
    function automatic reg_req_t make_req(input logic [4:0] idx, input logic wr,
                                          input logic [4:0] data);
        reg_req_t r;
        r.addr  = BASE_ADDR + {25'd0, idx, 2'b00};
        r.write = wr;
        r.wdata = wr ? {27'd0, data} : 32'd0;
        r.wstrb = wr ? 4'hF : 4'h0;
        r.valid = 1'b1;
        return r;
    endfunction

    // Next-state logic also computes the next registered bus request, so the
    // following transaction is presented on the cycle after a completion.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        verify_d  = verify_q;
        tbl_load  = 1'b0;
        req_d     = req_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        err_idx_d = err_idx_q;

        case (state_q)
            ST_IDLE: begin
                req_d  = '0;
                busy_d = 1'b0;
                if (start_i) begin
                    tbl_load  = 1'b1;
                    verify_d  = verify_i;
                    idx_d     = 5'd0;
                    err_d     = 1'b0;
                    err_idx_d = 5'd0;
                    busy_d    = 1'b1;
                    req_d     = make_req(5'd0, 1'b1, tbl_src[0]);
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (xfer) begin
                    if (reg_rsp_i.error) begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        req_d     = '0;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d = next_idx;
                        req_d = make_req(next_idx, 1'b1, tbl_q[next_idx]);
                    end else begin
                        idx_d = 5'd0;
                        if (verify_q) begin
                            req_d   = make_req(5'd0, 1'b0, 5'd0);
                            state_d = ST_READ;
                        end else begin
                            req_d   = '0;
                            done_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_READ: begin
                if (xfer) begin
                    if (reg_rsp_i.error || rd_bad) begin
                        err_d     = 1'b1;
                        err_idx_d = idx_q;
                        req_d     = '0;
                        done_d    = 1'b1;
                        state_d   = ST_DONE;
                    end else if (idx_q != LAST_IDX) begin
                        idx_d = next_idx;
                        req_d = make_req(next_idx, 1'b0, 5'd0);
                    end else begin
                        idx_d   = 5'd0;
                        req_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                req_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                req_d   = '0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= 5'd0;
            verify_q  <= 1'b0;
            req_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            verify_q  <= verify_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    // Table copy is only meaningful after a start, so it carries no reset.
    always_ff @(posedge clk_i) begin
        if (tbl_load) begin
            tbl_q <= tbl_src;
        end
    end

    assign reg_req_o = req_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign err_idx_o = err_idx_q;

endmodule

// File: tb/tb_sbox_lut_loader.sv
module tb_sbox_lut_loader;
    import reg_if_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          cyc;
        int          hold;
    } exp_t;

    typedef struct {
        int         cyc;
        logic       err;
        logic [4:0] idx;
    } done_exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             use_custom;
    logic             verify;
    logic [31:0][4:0] lut;
    reg_req_t         req;
    reg_rsp_t         rsp;
    logic             busy, done, err;
    logic [4:0]       err_idx;

    always #5 clk = ~clk;

    sbox_lut_loader #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .start_i     (start),
        .use_custom_i(use_custom),
        .verify_i    (verify),
        .lut_i       (lut),
        .reg_req_o   (req),
        .reg_rsp_i   (rsp),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .err_idx_o   (err_idx)
    );

    // Hand-copied ASCON S-box, index 0 first.
    logic [4:0] sbox_ref [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int t_start = 0;
    int done_cnt = 0;

    exp_t      exp_q[$];
    done_exp_t done_q[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, expv,
                     edge_cnt - t_start);
        end
    endtask

    // ---------------- responder: memory model with wait/error/corruption knobs
    int         waits = 0;
    int         corrupt_idx = -1;
    int         err_wr_idx = -1;
    int         wcnt = 0;
    int         ri;
    logic [4:0] mem [32];

    always @(negedge clk) begin
        rsp.ready = 1'b0;
        rsp.error = 1'b0;
        rsp.rdata = 32'd0;
        if (req.valid) begin
            if (wcnt < waits) begin
                wcnt++;
            end else begin
                wcnt = 0;
                rsp.ready = 1'b1;
                ri = int'(req.addr[6:2]);
                if (req.write) begin
                    if (ri == err_wr_idx) rsp.error = 1'b1;
                    else mem[ri] = req.wdata[4:0];
                end else begin
                    rsp.rdata = {27'h5A5A5A5, (ri == corrupt_idx) ? 5'h1F : mem[ri]};
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    // ---------------- monitor: pops expectations on completions and done pulses
    reg_req_t  prev_req;
    logic      prev_pend = 1'b0;
    int        hold = 0;
    int        cyc;
    exp_t      e;
    done_exp_t d;

    always begin
        @(negedge clk);
        #1;
        cyc = edge_cnt - t_start;
        if (req.valid) begin
            hold++;
            if (prev_pend) begin
                check("hold_addr", req.addr, prev_req.addr);
                check("hold_wdata", req.wdata, prev_req.wdata);
                check("hold_ctl", {27'd0, req.write, req.wstrb},
                      {27'd0, prev_req.write, prev_req.wstrb});
            end
            if (rsp.ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_txn: addr 0x%h write %0d at cycle %0d, none expected",
                             req.addr, req.write, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("txn_addr", req.addr, e.addr);
                    check("txn_write", {31'd0, req.write}, {31'd0, e.write});
                    check("txn_wdata", req.wdata, e.wdata);
                    check("txn_wstrb", {28'd0, req.wstrb}, {28'd0, e.wstrb});
                    check("txn_cycle", cyc, e.cyc);
                    check("txn_hold", hold, e.hold);
                end
                hold = 0;
                prev_pend = 1'b0;
            end else begin
                prev_pend = 1'b1;
                prev_req = req;
            end
        end else begin
            if (prev_pend) begin
                n_cmp++;
                n_bad++;
                $display("FAIL valid_drop: valid fell before completion at cycle %0d", cyc);
            end
            prev_pend = 1'b0;
            hold = 0;
        end
        if (done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done pulse at cycle %0d, none expected", cyc);
            end else begin
                d = done_q.pop_front();
                check("done_cycle", cyc, d.cyc);
                check("done_err", {31'd0, err}, {31'd0, d.err});
                check("done_err_idx", {27'd0, err_idx}, {27'd0, d.idx});
                check("done_busy", {31'd0, busy}, 32'd1);
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic push_txn(input int i, input logic wr, input logic [4:0] dat,
                            input int c, input int h);
        exp_t x;
        x.addr  = 32'(i * 4);
        x.write = wr;
        x.wdata = wr ? {27'd0, dat} : 32'd0;
        x.wstrb = wr ? 4'hF : 4'h0;
        x.cyc   = c;
        x.hold  = h;
        exp_q.push_back(x);
    endtask

    task automatic push_done(input int c, input logic e1, input logic [4:0] idx);
        done_exp_t x;
        x.cyc = c;
        x.err = e1;
        x.idx = idx;
        done_q.push_back(x);
    endtask

    task automatic start_load(input logic cust, input logic ver, input logic [31:0][4:0] tbl);
        @(negedge clk);
        start      = 1'b1;
        use_custom = cust;
        verify     = ver;
        lut        = tbl;
        t_start    = edge_cnt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt < target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: done count %0d, expected %0d", done_cnt, target);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_cycle(input int c);
        int n = 0;
        while ((edge_cnt - t_start) < c && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    logic [31:0][4:0] tbl;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        use_custom = 1'b0;
        verify = 1'b0;
        lut = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, req.valid}, 32'd0);
        check("rst_write", {31'd0, req.write}, 32'd0);
        check("rst_addr", req.addr, 32'd0);
        check("rst_wdata", req.wdata, 32'd0);
        check("rst_wstrb", {28'd0, req.wstrb}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_err_idx", {27'd0, err_idx}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Default table, no verify, zero-wait.
        for (int i = 0; i < 32; i++) push_txn(i, 1'b1, sbox_ref[i], 1 + i, 1);
        push_done(33, 1'b0, 5'd0);
        start_load(1'b0, 1'b0, '0);
        check("t1_busy_c1", {31'd0, busy}, 32'd1);
        check("t1_valid_c1", {31'd0, req.valid}, 32'd1);
        wait_done(1, 200);

        // Custom identity table, verify, two wait cycles per transaction.
        waits = 2;
        for (int i = 0; i < 32; i++) tbl[i] = 5'(i);
        for (int i = 0; i < 32; i++) push_txn(i, 1'b1, 5'(i), 3 * (i + 1), 3);
        for (int i = 0; i < 32; i++) push_txn(i, 1'b0, 5'd0, 3 * (33 + i), 3);
        push_done(193, 1'b0, 5'd0);
        start_load(1'b1, 1'b1, tbl);
        wait_done(2, 400);
        waits = 0;

        // Read-back mismatch at idx 7.
        corrupt_idx = 7;
        for (int i = 0; i < 32; i++) tbl[i] = 5'(31 - i);
        for (int i = 0; i < 32; i++) push_txn(i, 1'b1, 5'(31 - i), 1 + i, 1);
        for (int i = 0; i < 8; i++) push_txn(i, 1'b0, 5'd0, 33 + i, 1);
        push_done(41, 1'b1, 5'd7);
        start_load(1'b1, 1'b1, tbl);
        wait_done(3, 200);
        corrupt_idx = -1;
        check("t3_err_sticky", {31'd0, err}, 32'd1);
        check("t3_err_idx_sticky", {27'd0, err_idx}, 32'd7);

        // Bus error on the write of idx 3.
        err_wr_idx = 3;
        for (int i = 0; i < 4; i++) push_txn(i, 1'b1, sbox_ref[i], 1 + i, 1);
        push_done(5, 1'b1, 5'd3);
        start_load(1'b0, 1'b0, '0);
        wait_done(4, 200);
        err_wr_idx = -1;

        // Next start clears the error; a start pulse mid-load is ignored.
        for (int i = 0; i < 32; i++) push_txn(i, 1'b1, sbox_ref[i], 1 + i, 1);
        push_done(33, 1'b0, 5'd0);
        start_load(1'b0, 1'b0, '0);
        check("t5_err_cleared", {31'd0, err}, 32'd0);
        check("t5_err_idx_cleared", {27'd0, err_idx}, 32'd0);
        wait_cycle(10);
        start = 1'b1;
        use_custom = 1'b1;
        lut = '1;
        @(negedge clk);
        start = 1'b0;
        use_custom = 1'b0;
        wait_done(5, 200);
        check("t5_single_done", done_cnt, 5);

        // Reset at cycle 15 abandons the load; a fresh load starts from entry 0.
        for (int i = 0; i < 32; i++) tbl[i] = 5'(i) ^ 5'h15;
        for (int i = 0; i < 15; i++) push_txn(i, 1'b1, 5'(i) ^ 5'h15, 1 + i, 1);
        start_load(1'b1, 1'b0, tbl);
        wait_cycle(15);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_rst_valid", {31'd0, req.valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        check("t6_rst_addr", req.addr, 32'd0);
        check("t6_rst_wstrb", {28'd0, req.wstrb}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_partial_drained", exp_q.size(), 0);
        for (int i = 0; i < 32; i++) push_txn(i, 1'b1, sbox_ref[i], 1 + i, 1);
        push_done(33, 1'b0, 5'd0);
        start_load(1'b0, 1'b0, '0);
        wait_done(6, 200);

        check("end_txn_queue", exp_q.size(), 0);
        check("end_done_queue", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
